// File: rtl/spram_wb_pkg.sv
// Shared types for the single-port RAM Wishbone arbiter: FSM states and the
// per-master request bundle.
package spram_wb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
    } wb_req_t;

endpackage

// File: rtl/spram_wb_arbiter_rr.sv
// Two-request round-robin picker. On a tie the requester that did not win
// last time is chosen; the history only moves when adv_i is high.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic       valid_o,
    output logic       winner_o
);

    logic last_q;

    always_comb begin
        valid_o  = |req_i;
        winner_o = 1'b0;
        case (req_i)
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~last_q;
            default: winner_o = 1'b0;
        endcase
    end

    // Reset history points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (adv_i && valid_o) begin
            last_q <= winner_o;
        end
    end

endmodule

// File: rtl/spram_wb_arbiter.sv
// Shares one single-port synchronous RAM between two Wishbone classic masters,
// one access every two cycles. Define SPRAM_WB_ARB_ERR_EN for out-of-window err.
module spram_wb_arbiter
    import spram_wb_pkg::*;
#(
    parameter int unsigned SIZE       = 'h80,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE) - 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [31:0]           m0_adr,
    input  logic [31:0]           m0_wdat,
    output logic [31:0]           m0_rdat,
    output logic                  m0_ack,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [31:0]           m1_adr,
    input  logic [31:0]           m1_wdat,
    output logic [31:0]           m1_rdat,
    output logic                  m1_ack,
`ifdef SPRAM_WB_ARB_ERR_EN
    output logic                  m0_err,
    output logic                  m1_err,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_ce,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_d,
    input  logic [31:0]           ram_q
);

    wb_req_t                  req [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]   req_vec;
    wb_req_t                  win_req;
    logic                     arb_valid;
    logic                     arb_winner;
    logic                     arb_adv;
    arb_state_t               state_q, state_d;
    logic                     owner_q, owner_d;
    logic [NUM_MASTERS-1:0]   ack_v;
    logic [31:0]              rdat_v [NUM_MASTERS];
    logic                     addr_hit;
    logic                     unused_bits;

    assign req[0] = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, sel: m0_sel, adr: m0_adr, wdat: m0_wdat};
    assign req[1] = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, sel: m1_sel, adr: m1_adr, wdat: m1_wdat};

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
            assign req_vec[gi] = req[gi].cyc & req[gi].stb;
        end
    endgenerate

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_vec),
        .adv_i    (arb_adv),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

    assign win_req = req[arb_winner];

`ifdef SPRAM_WB_ARB_ERR_EN
    localparam int unsigned OFF_W = $clog2(SIZE);
    logic                   err_q, err_d;
    logic [NUM_MASTERS-1:0] err_v;
    assign addr_hit = (win_req.adr[31:OFF_W] == BASE_ADDR[31:OFF_W]);
    assign m0_err   = err_v[0];
    assign m1_err   = err_v[1];
`else
    // Without the window check the RAM aliases across the whole address space.
    assign addr_hit = 1'b1;
`endif

    assign unused_bits = ^{win_req.cyc, win_req.stb, win_req.adr[1:0],
                           win_req.adr[31:ADDR_WIDTH+2], BASE_ADDR};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
`ifdef SPRAM_WB_ARB_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef SPRAM_WB_ARB_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAM strobes are combinational in IDLE; gating on rst_n makes them drop
    // the instant reset asserts, not at the next edge.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        arb_adv   = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 4'b0;
        ram_addr  = '0;
        ram_d     = '0;
        ack_v     = '0;
        rdat_v[0] = '0;
        rdat_v[1] = '0;
`ifdef SPRAM_WB_ARB_ERR_EN
        err_d     = err_q;
        err_v     = '0;
`endif
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        arb_adv  = 1'b1;
                        ram_ce   = addr_hit;
                        ram_addr = win_req.adr[ADDR_WIDTH+1:2];
                        ram_we   = (win_req.we && addr_hit) ? win_req.sel : 4'b0;
                        ram_d    = win_req.wdat;
                        owner_d  = arb_winner;
                        state_d  = RESP;
`ifdef SPRAM_WB_ARB_ERR_EN
                        err_d    = ~addr_hit;
`endif
                    end
                end
                RESP: begin
                    state_d = IDLE;
`ifdef SPRAM_WB_ARB_ERR_EN
                    if (err_q) begin
                        err_v[owner_q] = req_vec[owner_q];
                    end else begin
                        ack_v[owner_q]  = req_vec[owner_q];
                        rdat_v[owner_q] = ram_q;
                    end
`else
                    ack_v[owner_q]  = req_vec[owner_q];
                    rdat_v[owner_q] = ram_q;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign m0_ack  = ack_v[0];
    assign m1_ack  = ack_v[1];
    assign m0_rdat = rdat_v[0];
    assign m1_rdat = rdat_v[1];

endmodule

// File: tb/tb_spram_wb_arbiter.sv
// Directed bench for spram_wb_arbiter with a behavioural RAM and a scoreboard
// of expected responses; covers SPRAM_WB_ARB_ERR_EN when defined.
module tb_spram_wb_arbiter;
    import spram_wb_pkg::*;

    localparam int SIZE = 'h80;
    localparam int AW   = $clog2(SIZE) - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]    m0_sel, m1_sel;
    logic [31:0]   m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic [31:0]   m0_rdat, m1_rdat;
    logic          m0_ack, m1_ack;
`ifdef SPRAM_WB_ARB_ERR_EN
    logic          m0_err, m1_err;
`endif
    logic [AW-1:0] ram_addr;
    logic          ram_ce;
    logic [3:0]    ram_we;
    logic [31:0]   ram_d;
    logic [31:0]   ram_q;
    logic [31:0]   mem [0:(SIZE/4)-1];

    typedef struct {
        int          m;
        bit          chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    spram_wb_arbiter #(.SIZE(SIZE), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
        .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_rdat(m0_rdat), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
        .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_rdat(m1_rdat), .m1_ack(m1_ack),
`ifdef SPRAM_WB_ARB_ERR_EN
        .m0_err(m0_err), .m1_err(m1_err),
`endif
        .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_d(ram_d), .ram_q(ram_q)
    );

    // Read-first synchronous RAM with byte enables.
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_q <= mem[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic we, input logic [3:0] sel,
                         input logic [31:0] adr, input logic [31:0] wdat);
        if (m == 0) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_sel = sel; m0_adr = adr; m0_wdat = wdat;
        end else begin
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_sel = sel; m1_adr = adr; m1_wdat = wdat;
        end
    endtask

    task automatic idle_m(input int m);
        if (m == 0) begin
            m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = '0;
        end else begin
            m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = '0;
        end
    endtask

    task automatic push(input int m, input bit c, input logic [31:0] d);
        exp_t e;
        e.m = m; e.chk = c; e.data = d;
        sb.push_back(e);
    endtask

    // Waits (bounded) for master m's ack, pops the scoreboard, then releases
    // the request one step after the next rising edge.
    task automatic wait_ack(input int m);
        bit   got = 1'b0;
        exp_t e;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk); #1;
            if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
        end
        chk($sformatf("ack_seen_m%0d", m), {31'b0, got}, 32'd1);
        if (got) begin
            chk("other_ack_low", (m == 0) ? m1_ack : m0_ack, 32'd0);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                if (e.chk) chk($sformatf("rdat_m%0d", m), (m == 0) ? m0_rdat : m1_rdat, e.data);
            end
            $display("txn m%0d acked rdat0=%h rdat1=%h", m, m0_rdat, m1_rdat);
        end
        @(posedge clk); #1;
        idle_m(m);
    endtask

    task automatic single(input int m, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] wdat,
                          input bit chk_rd, input logic [31:0] exp_rd);
        @(negedge clk);
        drive(m, we, sel, adr, wdat);
        push(m, chk_rd, exp_rd);
        #1;
        chk("ram_ce", ram_ce, 32'd1);
        chk("ram_addr", ram_addr, adr[AW+1:2]);
        chk("ram_we", ram_we, we ? sel : 4'b0);
        if (we) chk("ram_d", ram_d, wdat);
        wait_ack(m);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        idle_m(0);
        idle_m(1);
        drive(0, 1'b0, 4'hF, 32'h0, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h4, 32'h0);
        #3;
        chk("rst_m0_ack", m0_ack, 32'd0);
        chk("rst_m1_ack", m1_ack, 32'd0);
        chk("rst_ram_ce", ram_ce, 32'd0);
        chk("rst_ram_we", ram_we, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_d", ram_d, 32'd0);
        chk("rst_m0_rdat", m0_rdat, 32'd0);
        chk("rst_m1_rdat", m1_rdat, 32'd0);
`ifdef SPRAM_WB_ARB_ERR_EN
        chk("rst_m1_err", m1_err, 32'd0);
`endif

        // Both masters hold requests from reset: strict m0/m1 alternation.
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 1'b0, '0); push(1, 1'b0, '0); push(0, 1'b0, '0); push(1, 1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_m0_ack_c%0d", k), m0_ack, (k == 1 || k == 5));
            chk($sformatf("rr_m1_ack_c%0d", k), m1_ack, (k == 3 || k == 7));
            if (m0_ack || m1_ack) begin
                if (sb.size() == 0) begin
                    chk("rr_extra_ack", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("rr_order_c%0d", k), m1_ack ? 32'd1 : 32'd0, e.m);
                end
                $display("txn rr cycle %0d m0_ack=%0b m1_ack=%0b", k, m0_ack, m1_ack);
            end
            @(negedge clk);
        end
        idle_m(0);
        idle_m(1);
        chk("rr_sb_drained", sb.size(), 32'd0);

        single(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, '0);
        single(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
        single(1, 1'b1, 4'hF, 32'h30, 32'h11223344, 1'b0, '0);
        single(1, 1'b1, 4'b0010, 32'h30, 32'h0000AB00, 1'b0, '0);
        single(1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 32'h1122AB44);
        single(0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1'b0, '0);
        single(0, 1'b0, 4'hF, 32'h13, 32'h0, 1'b1, 32'hDEADBEEF);

        // m0 abandons its write while in RESP: no ack, write still lands.
        @(negedge clk);
        drive(0, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        m0_cyc = 1'b0;
        #1;
        chk("abandon_ack", m0_ack, 32'd0);
        @(negedge clk); #1;
        chk("abandon_ack_mid", m0_ack, 32'd0);
        @(posedge clk); #1;
        idle_m(0);
        $display("txn m0 abandoned write 0x20");
        single(0, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D);

`ifdef SPRAM_WB_ARB_ERR_EN
        @(negedge clk);
        drive(1, 1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        chk("err_ram_ce", ram_ce, 32'd0);
        @(negedge clk); #1;
        chk("err_m1_err", m1_err, 32'd1);
        chk("err_m1_ack", m1_ack, 32'd0);
        chk("err_m1_rdat", m1_rdat, 32'd0);
        $display("txn m1 out-of-window read err=%0b", m1_err);
        @(posedge clk); #1;
        idle_m(1);
        @(negedge clk); #1;
        chk("err_one_cycle", m1_err, 32'd0);
`else
        single(0, 1'b0, 4'hF, 32'h90, 32'h0, 1'b1, 32'hDEADBEEF);
`endif

        // Reset lands mid-RESP: ack drops with no clock edge; tie then goes to m0.
        @(negedge clk);
        drive(1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(posedge clk); #2;
        chk("pre_rst_m1_ack", m1_ack, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_m1_ack", m1_ack, 32'd0);
        chk("midrst_m0_ack", m0_ack, 32'd0);
        chk("midrst_ram_ce", ram_ce, 32'd0);
        chk("midrst_ram_we", ram_we, 32'd0);
        $display("txn async reset during m1 response");
        idle_m(1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 4'hF, 32'h10, 32'h0);
        drive(1, 1'b0, 4'hF, 32'h30, 32'h0);
        #1;
        chk("post_rst_tie_addr", ram_addr, 32'd4);
        push(0, 1'b1, 32'hDEADBEEF);
        wait_ack(0);
        push(1, 1'b1, 32'h1122AB44);
        wait_ack(1);

        chk("sb_empty_end", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

endmodule

// File: doc/spram_wb_arbiter.md
Name: spram_wb_arbiter

Overview:
- Two-port Wishbone classic arbiter that shares one single-port 32-bit synchronous RAM (1-cycle read latency, byte write enables) between two bus masters.
- Typical masters: core instruction fetch (m0) and data port (m1).
- Sequences RAM chip-enable, write-enable and data, returns read data, and generates acks.
- Round-robin arbitration; one access completes every two cycles.

Parameters:
- SIZE, 'h80: RAM size in bytes; power of two, at least 8.
- ADDR_WIDTH, $clog2(SIZE)-2: RAM word-address width (derived).
- BASE_ADDR, 32'h0: byte base address of the RAM window; aligned to SIZE.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_cyc, m1_cyc  in  1  Wishbone cycle.
- m0_stb, m1_stb  in  1  strobe; request = cyc & stb.
- m0_we, m1_we  in  1  1 = write.
- m0_sel, m1_sel  in  4  byte selects.
- m0_adr, m1_adr  in  32  byte address.
- m0_wdat, m1_wdat  in  32  write data.
- m0_rdat, m1_rdat  out  32  read data; valid while the matching ack is high.
- m0_ack, m1_ack  out  1  single-cycle acknowledge.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  4  RAM byte write enables.
- ram_d  out  32  RAM write data.
- ram_q  in  32  RAM read data; registered, valid 1 cycle after ce.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1 (m0 wins the first tie), ack_owner=0.
  - All acks 0. ram_ce 0. ram_we 0.
  - ram_addr, ram_d, rdat: 0.
- FSM states: IDLE, RESP.
- IDLE:
  - If any request, choose a winner:
    - only one requesting -> that master;
    - both requesting -> the master != last_grant.
  - Drive the RAM combinationally in the same cycle:
    - ram_ce=1;
    - ram_addr=adr[ADDR_WIDTH+1:2];
    - ram_we = sel if we, else 4'b0;
    - ram_d=wdat.
  - Register last_grant=ack_owner=winner, then go to RESP.
  - No request -> ram_ce=0, ram_we=0; stay in IDLE.
- RESP:
  - ram_ce=0.
  - ack_owner's ack=1 only if its cyc&stb are still high.
  - Its rdat=ram_q; the other master's rdat=0.
  - Always go to IDLE.
- Latency: request seen in IDLE at cycle N -> ack at cycle N+1. Throughput: one access per 2 cycles. Loser waits at most 2 cycles extra.
- Writes commit at edge N+1; the ack is informational.
- Master abandons (cyc drops) in RESP: no ack. A write already committed stays committed.
- Only the upper adr bits [31:$clog2(SIZE)] are compared, and only when the optional feature is on. adr[1:0] is ignored.
- sel=0 write: ram_ce=1, ram_we=0; ack still given.
- Back-to-back same master: it is re-arbitrated in the next IDLE. If the other master is requesting, the other master wins (round-robin).
- Reset mid-access: acks, ram_ce and ram_we drop to 0 immediately (asynchronous). An in-flight read returns nothing. An in-flight write has either occurred or not, depending on whether a clk edge fell in the window.

Optional Feature:
- Macro: SPRAM_WB_ARB_ERR_EN.
- Defined:
  - Adds ports m0_err and m1_err (out, 1, reset 0).
  - A request with adr[31:$clog2(SIZE)] != BASE_ADDR[31:$clog2(SIZE)] still wins arbitration normally.
  - ram_ce stays 0 for that access.
  - In RESP, err=1 instead of ack=1; rdat=0.
- Undefined:
  - No err ports and no address compare.
  - The upper address bits are ignored; the RAM aliases across the whole space.

Decomposition:
- Shared package spram_wb_pkg:
  - typedef enum logic {IDLE, RESP} arb_state_t;
  - typedef struct wb_req_t {cyc, stb, we, sel, adr, wdat};
  - localparam NUM_MASTERS=2.
- One natural sub-module, rr_arbiter2: a two-request round-robin picker holding last_grant, with an advance enable. It is reusable for other shared memories.

Test Plan:
- m0 write adr=0x10, sel=4'hF, wdat=0xDEADBEEF, then m0 read 0x10:
  - write cycle: ram_ce=1, ram_we=F, ram_addr=4;
  - m0_ack on the next cycle;
  - read acked 1 cycle after grant with m0_rdat=0xDEADBEEF.
- m1 write sel=4'b0010, wdat=0x0000AB00 to a word holding 0x11223344; read back -> 0x1122AB44.
- m0 and m1 request simultaneously from reset, both holding the request:
  - grant order m0, m1, m0, m1;
  - acks at cycles 1, 3, 5, 7; never both acks in one cycle.
- m0 drops cyc in RESP after a write to 0x20: no m0_ack; a later read of 0x20 returns the new data.
- Assert rst_n=0 while in RESP: m0_ack and m1_ack go 0 immediately with no clk edge; after release the FSM is IDLE and the first tie goes to m0.
- With SPRAM_WB_ARB_ERR_EN, SIZE='h80, BASE_ADDR=0: read adr=0x100 -> ram_ce stays 0, m1_err=1 for one cycle, m1_ack=0, m1_rdat=0.
